fetch_control_unit: RTL and testbench

Multi-cycle fetch and control sequencer directly upstream of `data_path`. It holds the program counter, reads 16-bit instructions from a synchronous instruction ROM, latches them into `instruct_reg`, decodes the opcode, and drives `data_path`'s control strobes for exactly the cycles each instruction needs. It consumes `jump_signal` from `data_path` to choose the next PC.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/fetch_control_unit_if.sv | 35 +++
 rtl/instr_decoder.sv | 43 ++++
 rtl/fetch_control_unit.sv | 113 +++++++++++
 tb/tb_fetch_control_unit.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcodes, FSM states and control bundle shared by the fetch/control unit
package cpu_pkg;

  localparam logic [3:0] OP_RTYPE  = 4'h0;
  localparam logic [3:0] OP_ALU_LO = 4'h1;
  localparam logic [3:0] OP_ALU_HI = 4'h6;
  localparam logic [3:0] OP_LOAD   = 4'h8;
  localparam logic [3:0] OP_STORE  = 4'h9;
  localparam logic [3:0] OP_BRANCH = 4'hA;
  localparam logic [3:0] OP_JUMP   = 4'hE;
  localparam logic [3:0] OP_HALT   = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_HALT
  } state_t;

  typedef struct packed {
    logic regdest;
    logic alusrc;
    logic memtoreg;
    logic regwrite;
    logic memread;
    logic memwrite;
    logic branch;
    logic jump;
  } ctrl_t;

endpackage

// File: rtl/fetch_control_unit_if.sv
// rtl/fetch_control_unit_if.sv - instruction ROM, data_path control and status signals
interface fetch_control_unit_if #(
  parameter int PC_WIDTH = 8
);
  logic                enable;
  logic [PC_WIDTH-1:0] imem_addr;
  logic [15:0]         imem_rdata;
  logic                jump_signal;
  logic [PC_WIDTH-1:0] PC;
  logic [15:0]         instruct_reg;
  logic                regdest;
  logic                alusrc;
  logic                memtoreg;
  logic                regwrite;
  logic                memread;
  logic                memwrite;
  logic                branch;
  logic                jump;
  logic                halted;
  logic                illegal;

  modport master (
    input  enable, imem_rdata, jump_signal,
    output imem_addr, PC, instruct_reg,
    output regdest, alusrc, memtoreg, regwrite, memread, memwrite, branch, jump,
    output halted, illegal
  );

  modport slave (
    output enable, imem_rdata, jump_signal,
    input  imem_addr, PC, instruct_reg,
    input  regdest, alusrc, memtoreg, regwrite, memread, memwrite, branch, jump,
    input  halted, illegal
  );
endinterface

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational opcode to control-bundle decode
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       in_mem,
  output ctrl_t      ctrl,
  output logic       is_illegal
);

  always_comb begin
    ctrl       = '0;
    is_illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.regdest  = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      OP_LOAD: begin
        ctrl.alusrc   = 1'b1;
        ctrl.memread  = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = in_mem;
      end
      OP_STORE: begin
        ctrl.alusrc   = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      OP_BRANCH: ctrl.branch = 1'b1;
      OP_JUMP:   ctrl.jump   = 1'b1;
      OP_HALT:   ctrl        = '0;
      default: begin
        if (opcode >= OP_ALU_LO && opcode <= OP_ALU_HI) begin
          ctrl.alusrc   = 1'b1;
          ctrl.regwrite = 1'b1;
        end else begin
          is_illegal = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/fetch_control_unit.sv
// rtl/fetch_control_unit.sv - multi-cycle fetch/decode/exec sequencer feeding data_path
// Optional illegal-opcode trap: FCU_ILLEGAL_TRAP_EN
module fetch_control_unit
  import cpu_pkg::*;
#(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input logic                  clk,
  input logic                  reset,
  fetch_control_unit_if.master bus
);

`ifdef FCU_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_t              state, state_nxt;
  logic [PC_WIDTH-1:0] pc, pc_nxt, pc_inc;
  logic                pc_load;
  logic [15:0]         ir;
  ctrl_t               dec_ctrl, ctrl;
  logic                dec_illegal;
  logic                trap;

  instr_decoder u_dec (
    .opcode    (ir[15:12]),
    .in_mem    (state == ST_MEM),
    .ctrl      (dec_ctrl),
    .is_illegal(dec_illegal)
  );

  // Strobes depend only on registered state and ir, so they are glitch-free
  // and fall with the asynchronous reset of the state register.
  assign ctrl = (state == ST_EXEC || state == ST_MEM) ? dec_ctrl : '0;
  assign trap = TRAP_EN && dec_illegal && (state == ST_EXEC);

  always_comb begin
    pc_inc = pc + PC_WIDTH'(1);
    pc_nxt = pc_inc;
    if (ctrl.jump && bus.jump_signal) begin
      pc_nxt = PC_WIDTH'(ir[7:0]);
    end else if (ctrl.branch && bus.jump_signal) begin
      pc_nxt = pc_inc + {{(PC_WIDTH-4){ir[3]}}, ir[3:0]};
    end
  end

  always_comb begin
    state_nxt = state;
    pc_load   = 1'b0;
    case (state)
      ST_FETCH:  if (bus.enable) state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (trap) begin
          state_nxt = ST_HALT;
        end else if (ir[15:12] == OP_LOAD) begin
          state_nxt = ST_MEM;
        end else if (ir[15:12] == OP_HALT) begin
          state_nxt = ST_HALT;
        end else begin
          state_nxt = ST_FETCH;
          pc_load   = 1'b1;
        end
      end
      ST_MEM: begin
        state_nxt = ST_FETCH;
        pc_load   = 1'b1;
      end
      ST_HALT:   state_nxt = ST_HALT;
      default:   state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_FETCH;
      pc    <= RESET_PC;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (pc_load) pc <= pc_nxt;
      if (state == ST_DECODE) ir <= bus.imem_rdata;
    end
  end

`ifdef FCU_ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) illegal_q <= 1'b0;
    else if (trap) illegal_q <= 1'b1;
  end
  assign bus.illegal = illegal_q;
`else
  assign bus.illegal = 1'b0;
`endif

  assign bus.imem_addr    = pc;
  assign bus.PC           = pc;
  assign bus.instruct_reg = ir;
  assign bus.halted       = (state == ST_HALT);
  assign bus.regdest      = ctrl.regdest;
  assign bus.alusrc       = ctrl.alusrc;
  assign bus.memtoreg     = ctrl.memtoreg;
  assign bus.regwrite     = ctrl.regwrite;
  assign bus.memread      = ctrl.memread;
  assign bus.memwrite     = ctrl.memwrite;
  assign bus.branch       = ctrl.branch;
  assign bus.jump         = ctrl.jump;

endmodule

// File: tb/tb_fetch_control_unit.sv
// tb/tb_fetch_control_unit.sv - directed bench for fetch_control_unit with a ROM model
module tb_fetch_control_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] rom [0:255];

  always #5 clk = ~clk;

  fetch_control_unit_if #(.PC_WIDTH(8)) bus ();

  fetch_control_unit #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always @(posedge clk) bus.imem_rdata <= rom[bus.imem_addr];

  // {regdest, alusrc, memtoreg, regwrite, memread, memwrite, branch, jump}
  function automatic logic [7:0] strobes();
    return {bus.regdest, bus.alusrc, bus.memtoreg, bus.regwrite,
            bus.memread, bus.memwrite, bus.branch, bus.jump};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(2);
    checks++; if (strobes() !== 8'h00) begin errors++; $display("FAIL reset_strobes got=%h exp=00", strobes()); end
    checks++; if (bus.PC !== 8'h00) begin errors++; $display("FAIL reset_pc got=%h exp=00", bus.PC); end
    checks++; if (bus.imem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got=%h exp=00", bus.imem_addr); end
    checks++; if (bus.instruct_reg !== 16'h0000) begin errors++; $display("FAIL reset_ir got=%h exp=0000", bus.instruct_reg); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", bus.halted); end
    checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%b exp=0", bus.illegal); end
    reset = 1'b0;
  endtask

  task automatic test_rtype();
    bus.enable = 1'b1; bus.jump_signal = 1'b0;
    step(1);
    checks++; if (strobes() !== 8'h00) begin errors++; $display("FAIL rtype_decode got=%h exp=00", strobes()); end
    step(1);
    checks++; if (strobes() !== 8'h90) begin errors++; $display("FAIL rtype_exec got=%h exp=90", strobes()); end
    checks++; if (bus.instruct_reg !== 16'h0123) begin errors++; $display("FAIL rtype_ir got=%h exp=0123", bus.instruct_reg); end
    checks++; if (bus.PC !== 8'h00) begin errors++; $display("FAIL rtype_pc_stable got=%h exp=00", bus.PC); end
    step(1);
    checks++; if (strobes() !== 8'h00) begin errors++; $display("FAIL rtype_after got=%h exp=00", strobes()); end
    checks++; if (bus.PC !== 8'h01) begin errors++; $display("FAIL rtype_pc got=%h exp=01", bus.PC); end
  endtask

  task automatic test_jump();
    bus.jump_signal = 1'b1;
    step(2);
    checks++; if (strobes() !== 8'h01) begin errors++; $display("FAIL jump_exec got=%h exp=01", strobes()); end
    step(1);
    checks++; if (bus.PC !== 8'h05) begin errors++; $display("FAIL jump_pc got=%h exp=05", bus.PC); end
  endtask

  task automatic test_load();
    bus.jump_signal = 1'b0;
    step(2);
    checks++; if (strobes() !== 8'h68) begin errors++; $display("FAIL load_exec got=%h exp=68", strobes()); end
    step(1);
    checks++; if (strobes() !== 8'h78) begin errors++; $display("FAIL load_mem got=%h exp=78", strobes()); end
    checks++; if (bus.PC !== 8'h05) begin errors++; $display("FAIL load_pc_stable got=%h exp=05", bus.PC); end
    step(1);
    checks++; if (strobes() !== 8'h00) begin errors++; $display("FAIL load_after got=%h exp=00", strobes()); end
    checks++; if (bus.PC !== 8'h06) begin errors++; $display("FAIL load_pc got=%h exp=06", bus.PC); end
  endtask

  task automatic test_branch();
    bus.jump_signal = 1'b1;
    step(3);
    checks++; if (bus.PC !== 8'h37) begin errors++; $display("FAIL jump37_pc got=%h exp=37", bus.PC); end
    step(3);
    checks++; if (bus.PC !== 8'h10) begin errors++; $display("FAIL jump10_pc got=%h exp=10", bus.PC); end
    step(2);
    checks++; if (strobes() !== 8'h02) begin errors++; $display("FAIL branch_exec got=%h exp=02", strobes()); end
    step(1);
    checks++; if (bus.PC !== 8'h0F) begin errors++; $display("FAIL branch_taken_pc got=%h exp=0f", bus.PC); end
    step(3);
    checks++; if (bus.PC !== 8'h10) begin errors++; $display("FAIL jump_back_pc got=%h exp=10", bus.PC); end
    bus.jump_signal = 1'b0;
    step(3);
    checks++; if (bus.PC !== 8'h11) begin errors++; $display("FAIL branch_not_taken_pc got=%h exp=11", bus.PC); end
    bus.jump_signal = 1'b1;
    step(3);
    checks++; if (bus.PC !== 8'h12) begin errors++; $display("FAIL rtype_ignores_js got=%h exp=12", bus.PC); end
    step(3);
    checks++; if (bus.PC !== 8'hFF) begin errors++; $display("FAIL jumpff_pc got=%h exp=ff", bus.PC); end
  endtask

  task automatic test_store_wrap();
    step(2);
    checks++; if (strobes() !== 8'h44) begin errors++; $display("FAIL store_exec got=%h exp=44", strobes()); end
    step(1);
    checks++; if (strobes() !== 8'h00) begin errors++; $display("FAIL store_after got=%h exp=00", strobes()); end
    checks++; if (bus.PC !== 8'h00) begin errors++; $display("FAIL store_wrap_pc got=%h exp=00", bus.PC); end
  endtask

  task automatic test_enable();
    bus.enable = 1'b0; bus.jump_signal = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      checks++; if (strobes() !== 8'h00 || bus.PC !== 8'h00)
        begin errors++; $display("FAIL enable_hold got=%h/%h exp=00/00", strobes(), bus.PC); end
    end
    bus.enable = 1'b1;
    step(1);
    bus.enable = 1'b0;
    step(1);
    checks++; if (strobes() !== 8'h90) begin errors++; $display("FAIL enable_drop_exec got=%h exp=90", strobes()); end
    step(1);
    checks++; if (bus.PC !== 8'h01) begin errors++; $display("FAIL enable_drop_pc got=%h exp=01", bus.PC); end
    step(3);
    checks++; if (strobes() !== 8'h00 || bus.PC !== 8'h01)
      begin errors++; $display("FAIL enable_refetch got=%h/%h exp=00/01", strobes(), bus.PC); end
  endtask

  task automatic test_illegal();
    rom[1] = 16'hB000;
    rom[2] = 16'hF000;
    bus.enable = 1'b1; bus.jump_signal = 1'b1;
    step(2);
    checks++; if (strobes() !== 8'h00) begin errors++; $display("FAIL illegal_exec got=%h exp=00", strobes()); end
    step(1);
`ifdef FCU_ILLEGAL_TRAP_EN
    checks++; if (bus.illegal !== 1'b1 || bus.halted !== 1'b1)
      begin errors++; $display("FAIL illegal_trap got=%b%b exp=11", bus.illegal, bus.halted); end
    checks++; if (bus.PC !== 8'h01) begin errors++; $display("FAIL illegal_pc got=%h exp=01", bus.PC); end
`else
    checks++; if (bus.illegal !== 1'b0 || bus.halted !== 1'b0)
      begin errors++; $display("FAIL illegal_nop got=%b%b exp=00", bus.illegal, bus.halted); end
    checks++; if (bus.PC !== 8'h02) begin errors++; $display("FAIL illegal_pc got=%h exp=02", bus.PC); end
`endif
  endtask

  task automatic test_halt();
    logic [7:0] exp_pc;
`ifdef FCU_ILLEGAL_TRAP_EN
    exp_pc = 8'h01;
`else
    exp_pc = 8'h02;
    step(2);
    checks++; if (strobes() !== 8'h00) begin errors++; $display("FAIL halt_exec got=%h exp=00", strobes()); end
    step(1);
`endif
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.halted !== 1'b1 || strobes() !== 8'h00 || bus.PC !== exp_pc)
        begin errors++; $display("FAIL halt_hold got=%b/%h/%h exp=1/00/%h", bus.halted, strobes(), bus.PC, exp_pc); end
      step(1);
    end
  endtask

  task automatic test_reset_mid_load();
    rom[0] = 16'h8456;
    test_reset();
    bus.enable = 1'b1; bus.jump_signal = 1'b0;
    step(3);
    checks++; if (strobes() !== 8'h78) begin errors++; $display("FAIL midload_mem got=%h exp=78", strobes()); end
    reset = 1'b1;
    #1;
    checks++; if (strobes() !== 8'h00) begin errors++; $display("FAIL midload_async_strobes got=%h exp=00", strobes()); end
    checks++; if (bus.PC !== 8'h00 || bus.instruct_reg !== 16'h0000)
      begin errors++; $display("FAIL midload_async_regs got=%h/%h exp=00/0000", bus.PC, bus.instruct_reg); end
    step(1);
    reset = 1'b0;
    step(2);
    checks++; if (strobes() !== 8'h68) begin errors++; $display("FAIL midload_restart got=%h exp=68", strobes()); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[8'h00] = 16'h0123;
    rom[8'h01] = 16'hE005;
    rom[8'h05] = 16'h8456;
    rom[8'h06] = 16'hE037;
    rom[8'h37] = 16'hE010;
    rom[8'h10] = 16'hA00E;
    rom[8'h0F] = 16'hE010;
    rom[8'h11] = 16'h0000;
    rom[8'h12] = 16'hE0FF;
    rom[8'hFF] = 16'h9000;
    bus.enable = 1'b0;
    bus.jump_signal = 1'b0;

    test_reset();
    test_rtype();
    test_jump();
    test_load();
    test_branch();
    test_store_wrap();
    test_enable();
    test_illegal();
    test_halt();
    test_reset_mid_load();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
